// File: rtl/muldiv_sequencer.sv
// Radix-2 multi-cycle multiply/divide unit owning HI/LO for mult, multu, div, divu.
// One iteration per clock on magnitudes; sign fix-up is applied in a final cycle.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] Op1,
    input  logic [WIDTH-1:0] Op2,
    input  logic             flush,
    input  logic             rd_hilo,
    output logic             busy,
    output logic             done,
    output logic             DivByZero,
    output logic             stall,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic               is_div_q, neg_q, remneg_q;
    logic [WIDTH-1:0]   den_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               busy_q, done_q, dbz_q;

    logic               op_signed, op_div;
    logic [WIDTH-1:0]   abs1, abs2;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign op_signed = ~op[0];
    assign op_div    = op[1];

    always_comb begin
        abs1 = (op_signed && Op1[WIDTH-1]) ? -Op1 : Op1;
        abs2 = (op_signed && Op2[WIDTH-1]) ? -Op2 : Op2;
    end

    // Multiply: acc = {partial, multiplier}, shifted right each step.
    // Divide: acc = {remainder, dividend}, shifted left; quotient bits enter at LSB.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, den_q} : '0);
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, den_q};
        div_ge    = (div_shift >= {1'b0, den_q});
        if (is_div_q)
            acc_d = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};
        else
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end

    always_comb begin
        prod_fix = neg_q    ? -acc_q                   : acc_q;
        quot_fix = neg_q    ? -acc_q[WIDTH-1:0]        : acc_q[WIDTH-1:0];
        rem_fix  = remneg_q ? -acc_q[2*WIDTH-1:WIDTH]  : acc_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            remneg_q <= 1'b0;
            den_q    <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !flush) begin
                        if (op_div && Op2 == '0) begin
                            done_q <= 1'b1;
                            dbz_q  <= 1'b1;
                        end else begin
                            is_div_q <= op_div;
                            neg_q    <= op_signed & (Op1[WIDTH-1] ^ Op2[WIDTH-1]);
                            remneg_q <= op_signed & Op1[WIDTH-1];
                            den_q    <= op_div ? abs2 : abs1;
                            acc_q    <= {{WIDTH{1'b0}}, (op_div ? abs1 : abs2)};
                            cnt_q    <= CW'(WIDTH - 1);
                            busy_q   <= 1'b1;
                            state_q  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        acc_q <= acc_d;
                        if (cnt_q == '0)
                            state_q <= FIX;
                        else
                            cnt_q <= cnt_q - CW'(1);
                    end
                end
                FIX: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    if (!flush) begin
                        done_q <= 1'b1;
                        if (is_div_q) begin
                            hi_q <= rem_fix;
                            lo_q <= quot_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign DivByZero = dbz_q;
    assign HI        = hi_q;
    assign LO        = lo_q;
    assign stall     = rd_hilo & (busy_q | (start & ~flush));

endmodule
